// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store sequencer: loadSrc codes, FSM states,
// and access-width helpers.
package lsu_pkg;

    localparam logic [2:0] LS_LB  = 3'b000;
    localparam logic [2:0] LS_LH  = 3'b001;
    localparam logic [2:0] LS_LW  = 3'b010;
    localparam logic [2:0] LS_LBU = 3'b011;
    localparam logic [2:0] LS_LHU = 3'b100;

    typedef enum logic [1:0] {IDLE, ACC1, ACC2, RESP} lsu_state_t;

    function automatic logic [2:0] size_bytes(input logic [2:0] ls);
        case (ls)
            LS_LB, LS_LBU: size_bytes = 3'd1;
            LS_LH, LS_LHU: size_bytes = 3'd2;
            default:       size_bytes = 3'd4;
        endcase
    endfunction

    // An access needs a second bus cycle when its bytes run past the word end.
    function automatic logic is_split(input logic [2:0] ls, input logic [1:0] off);
        is_split = ({1'b0, off} + size_bytes(ls)) > 3'd4;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: store data/mask shifted across two words, and load data
// merged from two words, extracted and extended.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [2:0]  size,
    input  logic [1:0]  off,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata1,
    input  logic [31:0] rdata2,
    output logic [31:0] wdata_lo,
    output logic [31:0] wdata_hi,
    output logic [3:0]  be_lo,
    output logic [3:0]  be_hi,
    output logic [31:0] rdata_ext
);

    logic [2:0]  nbytes;
    logic [63:0] wshift;
    logic [7:0]  mask;
    logic [31:0] merged;

    assign nbytes = size_bytes(size);
    assign wshift = {32'd0, wdata} << {off, 3'b000};

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_mask
            assign mask[gi] = (4'(gi) >= {2'b00, off}) &&
                              (4'(gi) < ({2'b00, off} + {1'b0, nbytes}));
        end
    endgenerate

    assign wdata_lo = wshift[31:0];
    assign wdata_hi = wshift[63:32];
    assign be_lo    = mask[3:0];
    assign be_hi    = mask[7:4];

    assign merged = 32'({rdata2, rdata1} >> {off, 3'b000});

    always_comb begin
        case (size)
            LS_LB:   rdata_ext = {{24{merged[7]}}, merged[7:0]};
            LS_LBU:  rdata_ext = {24'd0, merged[7:0]};
            LS_LH:   rdata_ext = {{16{merged[15]}}, merged[15:0]};
            LS_LHU:  rdata_ext = {16'd0, merged[15:0]};
            default: rdata_ext = merged;
        endcase
    end

endmodule

// File: rtl/lsu_seq.sv
// Load/store sequencer: one request becomes one or two word bus accesses with
// ack timeout. Define LSU_MISALIGN_TRAP_EN to fault split accesses instead.
module lsu_seq
    import lsu_pkg::*;
#(
    parameter int ACK_TIMEOUT = 255,
    parameter int TO_W        = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_size,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_data,
    output logic        resp_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam logic [TO_W-1:0] TO_LAST = TO_W'((ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0);

    lsu_state_t      state_reg, state_next;
    logic [2:0]      size_reg;
    logic [31:0]     addr_reg, wdata_reg, rdata1_reg, rdata2_reg;
    logic            we_reg, err_reg, err_next;
    logic [TO_W-1:0] wait_cnt_reg, wait_cnt_next;
    logic            accept, split, in_acc, timeout_hit;
    logic [31:0]     base_addr, al_wdata_lo, al_wdata_hi, al_rdata_ext;
    logic [3:0]      al_be_lo, al_be_hi;

    assign req_ready   = (state_reg == IDLE);
    assign accept      = req_valid && req_ready;
    assign split       = is_split(size_reg, addr_reg[1:0]);
    assign in_acc      = (state_reg == ACC1) || (state_reg == ACC2);
    assign mem_req     = in_acc;
    // An ack in the last allowed cycle completes the access normally.
    assign timeout_hit = (ACK_TIMEOUT != 0) && in_acc && !mem_ack && (wait_cnt_reg == TO_LAST);

    always_comb begin
        state_next = state_reg;
        err_next   = err_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    state_next = ACC1;
                    err_next   = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
                    if (is_split(req_size, req_addr[1:0])) begin
                        state_next = RESP;
                        err_next   = 1'b1;
                    end
`endif
                end
            end
            ACC1: begin
                if (mem_ack) begin
                    state_next = split ? ACC2 : RESP;
                end else if (timeout_hit) begin
                    state_next = RESP;
                    err_next   = 1'b1;
                end
            end
            ACC2: begin
                if (mem_ack) begin
                    state_next = RESP;
                end else if (timeout_hit) begin
                    state_next = RESP;
                    err_next   = 1'b1;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase

        wait_cnt_next = wait_cnt_reg;
        if (state_next != state_reg) begin
            wait_cnt_next = '0;
        end else if (in_acc && !mem_ack) begin
            wait_cnt_next = wait_cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= IDLE;
            err_reg      <= 1'b0;
            wait_cnt_reg <= '0;
            size_reg     <= '0;
            addr_reg     <= '0;
            we_reg       <= 1'b0;
            wdata_reg    <= '0;
            rdata1_reg   <= '0;
            rdata2_reg   <= '0;
        end else begin
            state_reg    <= state_next;
            err_reg      <= err_next;
            wait_cnt_reg <= wait_cnt_next;
            if (accept) begin
                size_reg   <= req_size;
                addr_reg   <= req_addr;
                we_reg     <= req_we;
                wdata_reg  <= req_wdata;
                rdata1_reg <= '0;
                rdata2_reg <= '0;
            end
            if (state_reg == ACC1 && mem_ack) rdata1_reg <= mem_rdata;
            if (state_reg == ACC2 && mem_ack) rdata2_reg <= mem_rdata;
        end
    end

    lsu_lane_align u_align (
        .size      (size_reg),
        .off       (addr_reg[1:0]),
        .wdata     (wdata_reg),
        .rdata1    (rdata1_reg),
        .rdata2    (rdata2_reg),
        .wdata_lo  (al_wdata_lo),
        .wdata_hi  (al_wdata_hi),
        .be_lo     (al_be_lo),
        .be_hi     (al_be_hi),
        .rdata_ext (al_rdata_ext)
    );

    assign base_addr = {addr_reg[31:2], 2'b00};

    // Bus outputs are driven only during an access and are zero otherwise.
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_be    = '0;
        if (in_acc) begin
            mem_we   = we_reg;
            mem_addr = (state_reg == ACC2) ? base_addr + 32'd4 : base_addr;
            if (we_reg) begin
                mem_wdata = (state_reg == ACC2) ? al_wdata_hi : al_wdata_lo;
                mem_be    = (state_reg == ACC2) ? al_be_hi : al_be_lo;
            end else begin
                mem_be = 4'hF;
            end
        end
    end

    assign resp_valid = (state_reg == RESP);
    assign resp_err   = resp_valid && err_reg;
    assign resp_data  = (resp_valid && !err_reg && !we_reg) ? al_rdata_ext : '0;

endmodule

// File: tb/tb_lsu_seq.sv
// Self-checking bench for lsu_seq: directed vector table, hand sequences for
// reset/stray-ack cases, and random traffic against a byte-level memory model.
module tb_lsu_seq;
    import lsu_pkg::*;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [2:0]  req_size = 3'd0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        req_ready, resp_valid, resp_err, mem_req, mem_we;
    logic [31:0] resp_data, mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = 32'd0;

    lsu_seq #(.ACK_TIMEOUT(TO), .TO_W(8)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        we;
    } access_t;

    typedef struct {
        bit          we;
        logic [2:0]  sz;
        logic [31:0] a, wd, w1, w2;
        int          d1, d2;
        logic [31:0] ed;
        bit          ee;
        int          el, erc;
    } vec_t;

    access_t     obs_q[$];
    int          delay_q[$];
    logic [7:0]  bmem[256];
    logic [7:0]  ref_mem[256];
    bit          stray_ack = 1'b0;
    int          total = 0;
    int          bad = 0;

    // Memory responder: ack after a per-access wait taken from delay_q.
    int r_wcnt = 0;
    int r_d = 0;
    bit r_loaded = 1'b0;
    always @(negedge clk) begin
        if (reset || !mem_req) begin
            mem_ack   = stray_ack;
            mem_rdata = $urandom;
            r_loaded  = 1'b0;
        end else begin
            if (!r_loaded) begin
                r_d = 0;
                if (delay_q.size() > 0) r_d = delay_q.pop_front();
                r_wcnt   = 0;
                r_loaded = 1'b1;
            end
            if (r_wcnt >= r_d) begin
                mem_ack = 1'b1;
                for (int b = 0; b < 4; b++) mem_rdata[8*b +: 8] = bmem[8'(mem_addr + 32'(b))];
                if (mem_we)
                    for (int b = 0; b < 4; b++)
                        if (mem_be[b]) bmem[8'(mem_addr + 32'(b))] = mem_wdata[8*b +: 8];
                obs_q.push_back('{mem_addr, mem_wdata, mem_be, mem_we});
                r_loaded = 1'b0;
            end else begin
                mem_ack   = 1'b0;
                mem_rdata = $urandom;
                r_wcnt++;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    task automatic chk_mem(input string nm);
        int first_bad;
        first_bad = -1;
        for (int i = 0; i < 256; i++)
            if (first_bad < 0 && bmem[i] !== ref_mem[i]) first_bad = i;
        total++;
        if (first_bad >= 0) begin
            bad++;
            $display("FAIL %s byte=%0d got=%h exp=%h", nm, first_bad, bmem[first_bad], ref_mem[first_bad]);
        end
    endtask

    task automatic preload(input logic [31:0] a, input logic [31:0] w);
        for (int b = 0; b < 4; b++) begin
            bmem[8'(a + 32'(b))]    = w[8*b +: 8];
            ref_mem[8'(a + 32'(b))] = w[8*b +: 8];
        end
    endtask

    // Reference: bytes addr..addr+n-1 little endian; timeout when wait >= TO.
    task automatic model(input bit we, input logic [2:0] sz, input logic [31:0] a, input logic [31:0] wd,
                         input int d1, input int d2, output logic [31:0] ed, output bit ee,
                         output int el, output int erc, output int eacc);
        int n, off, c1, c2;
        bit split, t1, t2;
        n = (sz == 3'd0 || sz == 3'd3) ? 1 : (sz == 3'd1 || sz == 3'd4) ? 2 : 4;
        off = int'(a[1:0]);
        split = (off + n) > 4;
        t1 = d1 >= TO;
        t2 = split && !t1 && d2 >= TO;
        c1 = t1 ? TO : d1 + 1;
        c2 = (split && !t1) ? (t2 ? TO : d2 + 1) : 0;
        ee = t1 || t2;
        el = c1 + c2 + 1;
        erc = c1 + c2;
        eacc = (t1 ? 0 : 1) + ((split && !t1 && !t2) ? 1 : 0);
        ed = 32'd0;
`ifdef LSU_MISALIGN_TRAP_EN
        if (split) begin
            ee = 1'b1; el = 1; erc = 0; eacc = 0;
            return;
        end
`endif
        if (!we && !ee) begin
            for (int i = 0; i < n; i++) ed[8*i +: 8] = ref_mem[8'(a + 32'(i))];
            if (sz == 3'd0 && ed[7])  ed = ed | 32'hFFFFFF00;
            if (sz == 3'd1 && ed[15]) ed = ed | 32'hFFFF0000;
        end
        if (we)
            for (int i = 0; i < n; i++)
                if ((off + i < 4) ? !t1 : (!t1 && !t2)) ref_mem[8'(a + 32'(i))] = wd[8*i +: 8];
    endtask

    // Issue one request (entered at a negedge) and wait for the response.
    task automatic run_txn(input bit we, input logic [2:0] sz, input logic [31:0] a, input logic [31:0] wd,
                           input int d1, input int d2, output logic [31:0] rd, output logic re,
                           output int lat, output int rc);
        int guard;
        delay_q.delete();
        delay_q.push_back(d1);
        delay_q.push_back(d2);
        obs_q.delete();
        guard = 0;
        while (!req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        req_we = we; req_size = sz; req_addr = a; req_wdata = wd; req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        rc = 0;
        while (!resp_valid && lat < 40) begin
            if (mem_req) rc++;
            @(negedge clk);
            lat++;
        end
        if (lat >= 40) chk("resp_wait_bound", 32'(resp_valid), 32'd1);
        rd = resp_data;
        re = resp_err;
        @(negedge clk);
    endtask

    vec_t vt[13];

    initial begin
        logic [31:0] rd, ed, ba;
        logic re;
        bit ee, rwe;
        int lat, rc, el, erc, eacc, seen, d1, d2;
        logic [2:0] rsz;
        logic [31:0] ra, rwd;
        int tix[4];

        for (int i = 0; i < 256; i++) begin
            bmem[i] = 8'($urandom);
            ref_mem[i] = bmem[i];
        end

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_err", 32'(resp_err), 32'd0);
        chk("rst_resp_data", resp_data, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_mem_be", 32'(mem_be), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd1);

        //        we  size    addr          wdata         w1            w2            d1 d2 exp_data      err lat rc
        vt[0]  = '{0, LS_LW,  32'h00000100, 32'h0,        32'hDEADBEEF, 32'h0,        0, 0, 32'hDEADBEEF, 0, 2, 1};
        vt[1]  = '{0, LS_LB,  32'h00000103, 32'h0,        32'h80FFFFFF, 32'h0,        0, 0, 32'hFFFFFF80, 0, 2, 1};
        vt[2]  = '{0, LS_LBU, 32'h00000103, 32'h0,        32'h80FFFFFF, 32'h0,        0, 0, 32'h00000080, 0, 2, 1};
        vt[3]  = '{0, LS_LH,  32'h00000203, 32'h0,        32'hAB000000, 32'h000000CD, 0, 0, 32'hFFFFCDAB, 0, 3, 2};
        vt[4]  = '{0, LS_LW,  32'h00000100, 32'h0,        32'hDEADBEEF, 32'h0,        9, 0, 32'h0,        1, 5, 4};
        vt[5]  = '{0, LS_LW,  32'h00000100, 32'h0,        32'hDEADBEEF, 32'h0,        3, 0, 32'hDEADBEEF, 0, 5, 4};
        vt[6]  = '{0, LS_LHU, 32'h00000102, 32'h0,        32'h80017777, 32'h0,        0, 0, 32'h00008001, 0, 2, 1};
        vt[7]  = '{0, LS_LH,  32'h00000102, 32'h0,        32'h80017777, 32'h0,        0, 0, 32'hFFFF8001, 0, 2, 1};
        vt[8]  = '{0, LS_LH,  32'hFFFFFFFF, 32'h0,        32'h12000000, 32'h00000034, 0, 0, 32'h00003412, 0, 3, 2};
        vt[9]  = '{0, LS_LW,  32'h00000401, 32'h0,        32'h44332211, 32'h88776655, 0, 0, 32'h55443322, 0, 3, 2};
        vt[10] = '{1, LS_LW,  32'h00000302, 32'h11223344, 32'h0,        32'h0,        0, 9, 32'h0,        1, 6, 5};
        vt[11] = '{1, LS_LB,  32'h00000105, 32'hAABBCCDD, 32'h0,        32'h0,        1, 0, 32'h0,        0, 3, 2};
        vt[12] = '{0, 3'b111, 32'h00000108, 32'h0,        32'h80000001, 32'h0,        0, 0, 32'h80000001, 0, 2, 1};
`ifdef LSU_MISALIGN_TRAP_EN
        tix = '{3, 8, 9, 10};
        for (int k = 0; k < 4; k++) begin
            vt[tix[k]].ed = 32'h0; vt[tix[k]].ee = 1'b1; vt[tix[k]].el = 1; vt[tix[k]].erc = 0;
        end
`else
        tix = '{0, 0, 0, 0};
`endif

        for (int v = 0; v < 13; v++) begin
            ba = {vt[v].a[31:2], 2'b00};
            preload(ba, vt[v].w1);
            preload(ba + 32'd4, vt[v].w2);
            model(vt[v].we, vt[v].sz, vt[v].a, vt[v].wd, vt[v].d1, vt[v].d2, ed, ee, el, erc, eacc);
            run_txn(vt[v].we, vt[v].sz, vt[v].a, vt[v].wd, vt[v].d1, vt[v].d2, rd, re, lat, rc);
            $display("vec %0d addr=%h size=%0d we=%0d -> data=%h err=%0d lat=%0d reqcyc=%0d",
                     v, vt[v].a, vt[v].sz, vt[v].we, rd, re, lat, rc);
            chk($sformatf("vec%0d_data", v), rd, vt[v].ed);
            chk($sformatf("vec%0d_err", v), 32'(re), 32'(vt[v].ee));
            chk($sformatf("vec%0d_lat", v), 32'(lat), 32'(vt[v].el));
            chk($sformatf("vec%0d_reqcyc", v), 32'(rc), 32'(vt[v].erc));
            chk_mem($sformatf("vec%0d_mem", v));
        end

        // Split store lane steering
        model(1'b1, LS_LW, 32'h302, 32'h11223344, 0, 0, ed, ee, el, erc, eacc);
        run_txn(1'b1, LS_LW, 32'h302, 32'h11223344, 0, 0, rd, re, lat, rc);
        $display("sw split -> err=%0d accesses=%0d", re, obs_q.size());
        chk("sw_split_naccess", 32'(obs_q.size()), 32'(eacc));
`ifndef LSU_MISALIGN_TRAP_EN
        if (obs_q.size() == 2) begin
            chk("sw_a1_addr", obs_q[0].addr, 32'h300);
            chk("sw_a1_be", 32'(obs_q[0].be), 32'hC);
            chk("sw_a1_wdata", obs_q[0].wdata, 32'h33440000);
            chk("sw_a2_addr", obs_q[1].addr, 32'h304);
            chk("sw_a2_be", 32'(obs_q[1].be), 32'h3);
            chk("sw_a2_wdata", obs_q[1].wdata, 32'h00001122);
        end
`endif
        chk("sw_split_err", 32'(re), 32'(ee));
        chk_mem("sw_split_mem");

        // Stray ack while idle must be ignored
        stray_ack = 1'b1;
        seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (resp_valid || mem_req || !req_ready) seen++;
        end
        stray_ack = 1'b0;
        $display("stray ack -> disturbances=%0d", seen);
        chk("stray_ack_ignored", 32'(seen), 32'd0);

        // Reset in the middle of an access abandons it silently
        delay_q.delete();
        obs_q.delete();
`ifdef LSU_MISALIGN_TRAP_EN
        delay_q.push_back(50);
        req_we = 1'b0; req_size = LS_LW; req_addr = 32'h100; req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
`else
        delay_q.push_back(0);
        delay_q.push_back(50);
        req_we = 1'b0; req_size = LS_LH; req_addr = 32'h203; req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
`endif
        chk("rst_mid_pre_req", 32'(mem_req), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_mid_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mid_ready", 32'(req_ready), 32'd1);
        chk("rst_mid_resp", 32'(resp_valid), 32'd0);
        reset = 1'b0;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (resp_valid) seen++;
        end
        $display("reset mid-access -> later responses=%0d", seen);
        chk("rst_mid_no_resp", 32'(seen), 32'd0);

        // Random traffic against the byte-level model
        for (int t = 0; t < 300; t++) begin
            rwe = 1'($urandom_range(0, 1));
            rsz = 3'($urandom_range(0, 7));
            ra  = ($urandom_range(0, 15) == 0) ? 32'hFFFFFF00 + 32'($urandom_range(0, 255))
                                               : 32'h00001000 + 32'($urandom_range(0, 255));
            rwd = $urandom;
            d1  = ($urandom_range(0, 9) < 8) ? int'($urandom_range(0, 2)) : int'($urandom_range(3, 6));
            d2  = ($urandom_range(0, 9) < 8) ? int'($urandom_range(0, 2)) : int'($urandom_range(3, 6));
            model(rwe, rsz, ra, rwd, d1, d2, ed, ee, el, erc, eacc);
            run_txn(rwe, rsz, ra, rwd, d1, d2, rd, re, lat, rc);
            $display("rnd %0d we=%0d size=%0d addr=%h d=%0d/%0d -> data=%h err=%0d lat=%0d",
                     t, rwe, rsz, ra, d1, d2, rd, re, lat);
            chk("rnd_data", rd, ed);
            chk("rnd_err", 32'(re), 32'(ee));
            chk("rnd_lat", 32'(lat), 32'(el));
            chk("rnd_reqcyc", 32'(rc), 32'(erc));
            chk("rnd_naccess", 32'(obs_q.size()), 32'(eacc));
            for (int k = 0; k < obs_q.size() && k < 2; k++) begin
                chk("rnd_acc_addr", obs_q[k].addr, {ra[31:2], 2'b00} + 32'(4 * k));
                if (!rwe) chk("rnd_rd_be", 32'(obs_q[k].be), 32'hF);
            end
            chk_mem("rnd_mem");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lsu_seq.md
Name: lsu_seq

Overview:
- Multi-cycle load/store sequencer between the core's memory stage and a word-wide, ack-handshaked data memory port.
- Accepts one load/store request and issues one or two word-aligned bus accesses; a second access is issued only when the access crosses a 4-byte boundary.
- Merges the returned read data, then byte-selects and sign- or zero-extends it using the core's existing loadSrc encoding.
- Returns a one-cycle response pulse, with an optional bus-timeout error.

Parameters:
- ACK_TIMEOUT, 255: maximum number of cycles one access may wait for mem_ack. 0 disables the timeout.
- TO_W, 8: width of the wait counter. Must satisfy ACK_TIMEOUT < 2**TO_W.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE; the request is accepted when req_valid && req_ready.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  3  loadSrc encoding: 010 LW, 001 LH, 000 LB, 100 LHU, 011 LBU.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- resp_valid  out  1  one-cycle completion pulse; no backpressure.
- resp_data  out  32  extended load data; 0 for stores and errors.
- resp_err  out  1  valid with resp_valid; timeout or misalign fault.
- mem_req  out  1  bus request, held until mem_ack.
- mem_we  out  1  bus write.
- mem_addr  out  32  word-aligned address (bits [1:0] = 00).
- mem_wdata  out  32  lane-shifted write data.
- mem_be  out  4  byte enables (all ones for reads).
- mem_ack  in  1  access complete; mem_rdata valid in the same cycle.
- mem_rdata  in  32  read data.

Behaviour:
- Reset: state IDLE, req_ready=1 in the following cycle. mem_req, resp_valid and resp_err are 0. resp_data, mem_addr, mem_wdata and mem_be are 0. Wait counter is 0.
- Reset during ACC1 or ACC2 abandons the access without a response. The memory must tolerate mem_req dropping.
- Request capture: size, address, write flag and data are registered when the request is accepted.
- Access width by req_size:
  - 000 and 011 → 1 byte.
  - 001 and 100 → 2 bytes.
  - 010 and 101–111 → 4 bytes.
- Sign extension applies to 000 and 001 only.
- Alignment: off = addr[1:0]. The access is split iff off + n > 4.
  - First access goes to {addr[31:2],00}.
  - Second access goes to the first address + 4, wrapping modulo 2^32.
- Store lanes:
  - 64-bit shifted data = req_wdata << 8*off.
  - 8-bit byte mask = ((1<<n)-1) << off.
  - The low halves of data and mask drive access 1; the high halves drive access 2.
- Load merge:
  - Capture rdata1 on the first mem_ack and rdata2 on the second.
  - Form {rdata2, rdata1} >> 8*off, keep the low n bytes, then extend.
  - For unsplit accesses rdata2 is 0.
- FSM:
  - IDLE → ACC1 on accept.
  - ACC1 → ACC2 on mem_ack when split; ACC1 → RESP on mem_ack when not split.
  - ACC2 → RESP on mem_ack.
  - ACC1 or ACC2 → RESP with the error flag set on timeout.
  - RESP → IDLE unconditionally.
- mem_req=1 only in ACC1 and ACC2. mem_* outputs are stable while mem_req=1 and mem_ack=0.
- resp_valid=1 only in RESP.
- mem_ack outside ACC1/ACC2 is ignored.
- Latency from the accept edge, with zero-wait memory: aligned access gives resp_valid at +2 cycles; split access at +3. req_ready returns one cycle after RESP.
- Back-to-back requests: the next accept is possible in the cycle after RESP, giving a throughput of one request per 3 cycles aligned.
- Timeout:
  - The counter clears on entering ACC1 or ACC2 and increments while mem_req && !mem_ack.
  - When it reaches ACK_TIMEOUT, mem_req drops and the FSM goes to RESP with resp_err=1 and resp_data=0.
  - For a split store that times out on access 2, the write from access 1 stands.
  - mem_ack arriving in the same cycle as the counter reaching the limit wins; no error is raised.

Optional Feature:
- LSU_MISALIGN_TRAP_EN defined:
  - A split-qualifying request goes IDLE → RESP with resp_err=1.
  - No mem_req is issued and no write is performed.
  - Latency is 1 cycle.
- LSU_MISALIGN_TRAP_EN undefined: split accesses are performed as described above.

Decomposition:
- Package lsu_pkg holds:
  - localparams LS_LB=3'b000, LS_LH=3'b001, LS_LW=3'b010, LS_LBU=3'b011, LS_LHU=3'b100.
  - Typedef lsu_state_t {IDLE, ACC1, ACC2, RESP}.
  - A width function size_bytes(loadSrc).
- Sub-module lsu_lane_align (combinational): 64-bit store shift and byte mask, and load merge/extract/extend. Instantiated once.

Test Plan:
- LW at 0x100, mem_rdata=0xDEADBEEF with ack on the first cycle → mem_addr=0x100, mem_be=1111; resp_valid at +2 with resp_data=0xDEADBEEF, resp_err=0.
- LB at 0x103, rdata=0x80FFFFFF → resp_data=0xFFFFFF80. LBU at the same address → resp_data=0x00000080. Both unsplit with a single mem_req.
- LH at 0x203 with rdata1=0xAB000000 and rdata2=0x000000CD → two accesses to 0x200 then 0x204; resp_data=0xFFFFCDAB at +3.
- SW 0x11223344 at 0x302 → access 1: addr 0x300, be=1100, wdata=0x33440000; access 2: addr 0x304, be=0011, wdata=0x00001122.
- mem_ack withheld with ACK_TIMEOUT=4 → mem_req high for exactly 4 cycles, then resp_valid=1, resp_err=1, resp_data=0. Separately, reset asserted in ACC2 → next cycle mem_req=0, req_ready=1, and no resp_valid.
- With LSU_MISALIGN_TRAP_EN defined, LW at 0x401 → no mem_req, resp_err=1 one cycle after accept.
